// File: rtl/tiny_eth_pkg.sv
// Shared types and CRC-32 constants for the tiny_eth receive path.
package tiny_eth_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RX    = 2'd1,
    CHECK = 2'd2,
    TX    = 2'd3
  } state_t;

  localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_REFL = 32'hDEBB20E3;

endpackage

// File: rtl/tiny_eth_crc32_serial.sv
// Bit-serial reflected CRC-32 register, one line bit per enabled clock.
module tiny_eth_crc32_serial
  import tiny_eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        dbit,
  output logic [31:0] crc
);

  logic fb;
  assign fb = crc[0] ^ dbit;

  // Shift right, folding in the reflected polynomial when the feedback bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= (crc >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0);
  end

endmodule

// File: rtl/tiny_eth_mac.sv
// Receive-side MAC front end: preamble/SFD hunt, fixed-length capture,
// FCS check, and bit-serial replay of frames that pass.
module tiny_eth_mac
  import tiny_eth_pkg::*;
#(
  parameter int FRAME_BYTES  = 64,
  parameter int PRE_MIN_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int FBITS = FRAME_BYTES * 8;
  localparam int AW    = $clog2(FBITS);
  // One extra bit so TX can count one past the last bit and exit with q=0.
  localparam int IW    = AW + 1;

  state_t           state, state_nx;
  logic [FBITS-1:0] fbuf;
  logic [IW-1:0]    idx;
  logic             prev;
  logic [7:0]       run;
  logic [31:0]      crc;
  logic             sfd, last_rx, last_tx, crc_ok;

  // SFD: second '1' of the closing "11", with a long enough alternating run behind it.
  assign sfd     = (state == HUNT) && d && prev && (run >= 8'(PRE_MIN_BITS));
  assign last_rx = (idx == IW'(FBITS - 1));
  assign last_tx = (idx == IW'(FBITS));
  assign crc_ok  = (crc == CRC32_RESIDUE_REFL);

  tiny_eth_crc32_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (sfd),
    .en   (state == RX),
    .dbit (d),
    .crc  (crc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      HUNT:  if (sfd) state_nx = RX;
      RX:    if (last_rx) state_nx = CHECK;
      CHECK: state_nx = crc_ok ? TX : HUNT;
      TX:    if (last_tx) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  // Hunt tracking, bit index and registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      prev <= 1'b0;
      run  <= 8'd0;
      q    <= 1'b0;
    end else begin
      q <= 1'b0;
      case (state)
        HUNT: begin
          prev <= d;
          run  <= (d != prev) ? ((run == 8'hFF) ? run : run + 8'd1) : 8'd1;
          if (sfd) idx <= '0;
        end
        RX:    idx <= idx + IW'(1);
        CHECK: idx <= '0;
        TX: begin
          if (last_tx) begin
            idx <= '0;
            run <= 8'd0;
          end else begin
            q   <= fbuf[idx[AW-1:0]];
            idx <= idx + IW'(1);
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  // Frame buffer; contents are only meaningful after a full capture, so no reset.
  always_ff @(posedge clk) begin
    if (state == RX) fbuf[idx[AW-1:0]] <= d;
  end

endmodule

// File: tb/tb_tiny_eth_mac.sv
// Bench for tiny_eth_mac: frames built with a reference CRC-32, expected
// replay bits queued per clock and compared as q comes out.
module tb_tiny_eth_mac;
  import tiny_eth_pkg::*;

  localparam int FB = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b1;
  logic q;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int last_edge = 0;

  typedef struct { int cyc; logic b; } exp_t;
  exp_t sb[$];

  logic [FB-1:0] fa, fa_bad, fb;

  always #10 clk = ~clk;

  tiny_eth_mac #(.FRAME_BYTES(64), .PRE_MIN_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ecount, got, exp);
    end
  endtask

  // Every cycle q either matches the next queued bit or must be 0.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == ecount) begin
      chk("q_bit", {31'd0, q}, {31'd0, sb[0].b});
      void'(sb.pop_front());
    end else begin
      chk("q_idle", {31'd0, q}, 32'd0);
    end
  end

  function automatic logic [31:0] crc32(input logic [7:0] by[60]);
    logic [31:0] c;
    logic f;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++)
      for (int j = 0; j < 8; j++) begin
        f = c[0] ^ by[i][j];
        c = c >> 1;
        if (f) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  task automatic build(input int kind, output logic [FB-1:0] f);
    logic [7:0]  by[60];
    logic [31:0] fcs;
    for (int i = 0; i < 60; i++) by[i] = (kind == 0) ? 8'(i) : 8'(i * 3 + 7);
    fcs = ~crc32(by);
    for (int i = 0; i < 60; i++) f[i*8 +: 8] = by[i];
    for (int i = 0; i < 4; i++)  f[(60+i)*8 +: 8] = fcs[i*8 +: 8];
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    d = b;
    last_edge = ecount + 1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  // alt_n alternating bits starting with 1, then "11", then the frame body.
  task automatic send_frame(input logic [FB-1:0] f, input int alt_n, input bit push);
    for (int i = 0; i < alt_n; i++) send_bit((i % 2) == 0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < FB; i++) send_bit(f[i]);
    if (push)
      for (int k = 0; k < FB; k++) sb.push_back('{last_edge + 2 + k, f[k]});
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int tx_edge;
    build(0, fa);
    build(1, fb);
    fa_bad = fa;
    fa_bad[100] = ~fa_bad[100];

    // Reset with line held high.
    #5 chk("rst_q", {31'd0, q}, 32'd0);
    #10 rst = 1'b0;
    repeat (6) send_bit(1'b1);
    chk("hunt_state", 32'(dut.state), 32'(HUNT));
    send_idle(4);

    // Good frame replayed.
    send_frame(fa, 62, 1'b1);
    send_idle(600);

    // Corrupted frame dropped, following good frame accepted.
    send_frame(fa_bad, 62, 1'b0);
    send_frame(fb, 62, 1'b1);
    send_idle(600);

    // Too-short preamble: no detection.
    send_frame(fa, 8, 1'b0);
    send_idle(600);

    // Reset during TX bit 200, then a fresh good frame.
    send_frame(fa, 62, 1'b1);
    tx_edge = last_edge + 2 + 200;
    while (ecount < tx_edge) send_bit(1'b0);
    #5 rst = 1'b1;
    sb.delete();
    #1 chk("rst_async_q", {31'd0, q}, 32'd0);
    @(negedge clk);
    chk("rst_state", 32'(dut.state), 32'(HUNT));
    #5 rst = 1'b0;
    send_frame(fb, 62, 1'b1);
    send_idle(600);

    // Second frame arriving during replay of the first is lost.
    send_frame(fa, 62, 1'b1);
    send_frame(fb, 62, 1'b0);
    send_idle(600);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
